// File: rtl/arc4_pkg.sv
// arc4_pkg: shared state/phase types, S-memory widths and default phase timeout.
package arc4_pkg;
  localparam int S_ADDR_W = 8;
  localparam int S_DATA_W = 8;
  localparam int TIMEOUT_DEF = 1024;
  typedef enum logic [2:0] {
    IDLE, START_INIT, WAIT_INIT, START_KSA, WAIT_KSA, START_PRGA, WAIT_PRGA
  } state_t;
  typedef enum logic [1:0] {PH_NONE = 2'd0, PH_INIT = 2'd1, PH_KSA = 2'd2, PH_PRGA = 2'd3} phase_t;
  function automatic phase_t owner(input state_t s);
    return (s == START_INIT || s == WAIT_INIT) ? PH_INIT :
           (s == START_KSA  || s == WAIT_KSA)  ? PH_KSA  :
           (s == START_PRGA || s == WAIT_PRGA) ? PH_PRGA : PH_NONE;
  endfunction
endpackage

// File: rtl/arc4_smem_mux.sv
// arc4_smem_mux: combinational three-way S-port mux selected by the current owner phase.
module arc4_smem_mux
  import arc4_pkg::*;
(
  input  phase_t              phase,
  input  logic [S_ADDR_W-1:0] init_addr,
  input  logic [S_DATA_W-1:0] init_wrdata,
  input  logic                init_wren,
  input  logic [S_ADDR_W-1:0] ksa_addr,
  input  logic [S_DATA_W-1:0] ksa_wrdata,
  input  logic                ksa_wren,
  input  logic [S_ADDR_W-1:0] prga_addr,
  input  logic [S_DATA_W-1:0] prga_wrdata,
  input  logic                prga_wren,
  output logic [S_ADDR_W-1:0] s_addr,
  output logic [S_DATA_W-1:0] s_wrdata,
  output logic                s_wren
);
  // only the owning engine reaches the memory; no owner parks the port at zero
  always_comb begin
    s_addr   = phase == PH_INIT ? init_addr   : phase == PH_KSA ? ksa_addr   : phase == PH_PRGA ? prga_addr   : '0;
    s_wrdata = phase == PH_INIT ? init_wrdata : phase == PH_KSA ? ksa_wrdata : phase == PH_PRGA ? prga_wrdata : '0;
    s_wren   = phase == PH_INIT ? init_wren   : phase == PH_KSA ? ksa_wren   : phase == PH_PRGA ? prga_wren   : 1'b0;
  end
endmodule

// File: rtl/arc4_ctrl.sv
// arc4_ctrl: sequences init/ksa/prga over en/rdy, owns the S-port mux, latches the key, flags hung engines.
module arc4_ctrl
  import arc4_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int KEY_W   = 24
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  output logic                rdy,
  output logic                err,
  output logic [1:0]          phase,
  input  logic [KEY_W-1:0]    key,
  output logic [KEY_W-1:0]    key_q,
  output logic                init_en,
  output logic                ksa_en,
  output logic                prga_en,
  input  logic                init_rdy,
  input  logic                ksa_rdy,
  input  logic                prga_rdy,
  input  logic [S_ADDR_W-1:0] init_addr,
  input  logic [S_ADDR_W-1:0] ksa_addr,
  input  logic [S_ADDR_W-1:0] prga_addr,
  input  logic [S_DATA_W-1:0] init_wrdata,
  input  logic [S_DATA_W-1:0] ksa_wrdata,
  input  logic [S_DATA_W-1:0] prga_wrdata,
  input  logic                init_wren,
  input  logic                ksa_wren,
  input  logic                prga_wren,
  output logic [S_ADDR_W-1:0] s_addr,
  output logic [S_DATA_W-1:0] s_wrdata,
  output logic                s_wren
);
  state_t      state, nxt;
  phase_t      own;
  logic [15:0] cnt;
  logic        cur_rdy, tout, accept;
  // next state, start pulses and status; exit condition wins over timeout
  always_comb begin
    own     = owner(state);
    cur_rdy = own == PH_INIT ? init_rdy : own == PH_KSA ? ksa_rdy : own == PH_PRGA ? prga_rdy : 1'b0;
    tout    = cnt == 16'(TIMEOUT - 1);
    accept  = state == IDLE && en;
    rdy     = state == IDLE;
    init_en = state == START_INIT && init_rdy;
    ksa_en  = state == START_KSA && ksa_rdy;
    prga_en = state == START_PRGA && prga_rdy;
    nxt     = state == IDLE ? (en ? START_INIT : IDLE) :
              cur_rdy ? (state == WAIT_PRGA ? IDLE : state_t'(state + 3'd1)) :
              tout ? IDLE : state;
  end
  // state register, per-state cycle counter, sticky error and key latch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      err   <= 1'b0;
      key_q <= '0;
    end else begin
      state <= nxt;
      cnt   <= (nxt != state || state == IDLE) ? '0 : cnt + 16'd1;
      if (accept) begin
        err   <= 1'b0;
        key_q <= key;
      end else if (state != IDLE && !cur_rdy && tout) begin
        err <= 1'b1;
      end
    end
  end
  assign phase = own;
  arc4_smem_mux u_mux (
    .phase      (own),
    .init_addr  (init_addr),
    .init_wrdata(init_wrdata),
    .init_wren  (init_wren),
    .ksa_addr   (ksa_addr),
    .ksa_wrdata (ksa_wrdata),
    .ksa_wren   (ksa_wren),
    .prga_addr  (prga_addr),
    .prga_wrdata(prga_wrdata),
    .prga_wren  (prga_wren),
    .s_addr     (s_addr),
    .s_wrdata   (s_wrdata),
    .s_wren     (s_wren)
  );
endmodule

// File: tb/tb_arc4_ctrl.sv
// tb_arc4_ctrl: randomized run scenarios against behavioural engine models and phase-sum latency reference.
module tb_arc4_ctrl;
  localparam int TO = 16;
  logic        clk = 1'b0, rst_n = 1'b0, en = 1'b0;
  logic [23:0] key = '0, key_q;
  logic        rdy, err, init_en, ksa_en, prga_en, init_rdy, ksa_rdy, prga_rdy;
  logic [1:0]  phase;
  logic [7:0]  s_addr, s_wrdata;
  logic        s_wren;
  logic        er[3];
  logic [7:0]  ea[3], ed[3];
  logic        ew[3];
  int          b[3], dly[3], left[3], wcnt[3], pulses[3];
  bit          started[3], stuck[3], ens[3];
  int          checks = 0, errors = 0;
  int          nxt_en, last_ph, mux_bad, ord_bad, key_bad, lat;
  logic [16:0] mux_act, mux_exp;
  logic [23:0] cur_key;

  assign init_rdy = er[0];
  assign ksa_rdy  = er[1];
  assign prga_rdy = er[2];

  always #5 clk = ~clk;

  arc4_ctrl #(.TIMEOUT(TO), .KEY_W(24)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy), .err(err), .phase(phase),
    .key(key), .key_q(key_q),
    .init_en(init_en), .ksa_en(ksa_en), .prga_en(prga_en),
    .init_rdy(init_rdy), .ksa_rdy(ksa_rdy), .prga_rdy(prga_rdy),
    .init_addr(ea[0]), .ksa_addr(ea[1]), .prga_addr(ea[2]),
    .init_wrdata(ed[0]), .ksa_wrdata(ed[1]), .prga_wrdata(ed[2]),
    .init_wren(ew[0]), .ksa_wren(ew[1]), .prga_wren(ew[2]),
    .s_addr(s_addr), .s_wrdata(s_wrdata), .s_wren(s_wren)
  );

  task automatic setup(input int b0, input int b1, input int b2, input int d1, input bit st2);
    b[0] = b0; b[1] = b1; b[2] = b2;
    for (int e = 0; e < 3; e++) begin
      dly[e] = 0; left[e] = 0; wcnt[e] = 0; pulses[e] = 0;
      started[e] = 0; stuck[e] = 0; ens[e] = 0; er[e] = 1'b1;
      ea[e] = 8'(e * 85 + $urandom_range(0, 80));
      ed[e] = 8'($urandom);
      ew[e] = 1'b1;
    end
    dly[1] = d1;
    er[1] = (d1 == 0);
    stuck[2] = st2;
  endtask

  task automatic observe();
    int p;
    logic [16:0] ex;
    @(negedge clk);
    ens[0] = init_en; ens[1] = ksa_en; ens[2] = prga_en;
    p = int'(phase);
    for (int e = 0; e < 3; e++) begin
      if (ens[e]) begin
        pulses[e]++;
        if (e != nxt_en || p != e + 1) ord_bad++;
        nxt_en++;
      end
      if (p == e + 1 && !started[e] && !er[e]) wcnt[e]++;
    end
    if (p != last_ph) begin
      if (p != (last_ph + 1) % 4) ord_bad++;
      last_ph = p;
    end
    ex = p == 0 ? 17'd0 : {ea[p-1], ed[p-1], ew[p-1]};
    if ({s_addr, s_wrdata, s_wren} !== ex) begin
      mux_bad++; mux_act = {s_addr, s_wrdata, s_wren}; mux_exp = ex;
    end
    if (p != 0 && key_q !== cur_key) key_bad++;
  endtask

  task automatic update();
    @(posedge clk);
    #1;
    for (int e = 0; e < 3; e++) begin
      if (ens[e]) begin
        er[e] = 1'b0; left[e] = b[e] - 1; started[e] = 1;
      end else if (!started[e] && !er[e] && wcnt[e] >= dly[e]) begin
        er[e] = 1'b1;
      end else if (started[e] && !er[e] && !stuck[e]) begin
        if (left[e] == 0) er[e] = 1'b1;
        else left[e]--;
      end
      ens[e] = 0;
    end
  endtask

  task automatic begin_run(input logic [23:0] k);
    cur_key = k; nxt_en = 0; last_ph = 0; mux_bad = 0; ord_bad = 0; key_bad = 0;
    en = 1'b1; key = k;
    update();
    en = 1'b0; key = 24'($urandom);
  endtask

  task automatic run(input logic [23:0] k, input int exp_lat, input bit exp_err, input bit stuck_run);
    begin_run(k);
    lat = 0;
    observe();
    while (!rdy && lat < 200) begin
      en = 1'($urandom_range(0, 1)); key = 24'($urandom);
      update();
      en = 1'b0;
      lat++;
      observe();
    end
    checks++; if (lat !== exp_lat) begin errors++; $display("FAIL latency: got %0d expected %0d", lat, exp_lat); end
    checks++; if (pulses[0] !== 1 || pulses[1] !== 1 || pulses[2] !== 1) begin errors++; $display("FAIL en_pulses: got %0d/%0d/%0d expected 1/1/1", pulses[0], pulses[1], pulses[2]); end
    checks++; if (ord_bad !== 0 || last_ph !== 0) begin errors++; $display("FAIL sequence: %0d order violations, final phase %0d expected 0 violations, phase 0", ord_bad, last_ph); end
    checks++; if (err !== exp_err) begin errors++; $display("FAIL err: got %b expected %b", err, exp_err); end
    checks++; if (key_q !== k || key_bad !== 0) begin errors++; $display("FAIL key_q: got %h (%0d unstable cycles) expected %h", key_q, key_bad, k); end
    checks++; if (mux_bad !== 0) begin errors++; $display("FAIL s_mux: %0d bad cycles, last got %h expected %h", mux_bad, mux_act, mux_exp); end
    if (stuck_run) er[2] = 1'b1;
  endtask

  task automatic test_reset();
    setup(3, 5, 4, 0, 0);
    rst_n = 1'b0;
    #2;
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy: got %b expected 1", rdy); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
    checks++; if (phase !== 2'd0) begin errors++; $display("FAIL reset_phase: got %0d expected 0", phase); end
    checks++; if ({s_addr, s_wrdata, s_wren} !== 17'd0) begin errors++; $display("FAIL reset_s: got %h expected 0", {s_addr, s_wrdata, s_wren}); end
    checks++; if (key_q !== 24'd0) begin errors++; $display("FAIL reset_key_q: got %h expected 0", key_q); end
    checks++; if ({init_en, ksa_en, prga_en} !== 3'b000) begin errors++; $display("FAIL reset_en: got %b expected 000", {init_en, ksa_en, prga_en}); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_happy();
    setup(3, 5, 4, 0, 0);
    run(24'h1E4600, 18, 0, 0);
  endtask

  task automatic test_mux();
    setup(2, 2, 2, 0, 0);
    ea[0] = 8'h11; ea[1] = 8'h22; ea[2] = 8'h33;
    run(24'($urandom), 12, 0, 0);
    checks++; if (s_wren !== 1'b0 || s_addr !== 8'h00) begin errors++; $display("FAIL idle_s: got wren %b addr %h expected 0 00", s_wren, s_addr); end
  endtask

  task automatic test_delay();
    setup(3, 5, 4, 4, 0);
    run(24'($urandom), 22, 0, 0);
  endtask

  task automatic test_timeout();
    setup(2, 3, 1, 0, 1);
    run(24'($urandom), 4 + 5 + 1 + TO, 1, 1);
    setup(1, 1, 1, 0, 0);
    run(24'($urandom), 9, 0, 0);
  endtask

  task automatic test_mid_reset();
    int n;
    setup(3, 5, 4, 0, 0);
    begin_run(24'hABCDEF);
    n = 0;
    observe();
    while (pulses[1] == 0 && n < 40) begin
      update();
      n++;
      observe();
    end
    update();
    checks++; if (phase !== 2'd2 || rdy !== 1'b0) begin errors++; $display("FAIL pre_reset: got phase %0d rdy %b expected 2 0", phase, rdy); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (rdy !== 1'b1 || phase !== 2'd0) begin errors++; $display("FAIL mid_reset: got rdy %b phase %0d expected 1 0", rdy, phase); end
    checks++; if (key_q !== 24'd0 || s_wren !== 1'b0) begin errors++; $display("FAIL mid_reset_q: got key_q %h wren %b expected 0 0", key_q, s_wren); end
    @(negedge clk);
    rst_n = 1'b1;
    setup(3, 5, 4, 0, 0);
    run(24'h123456, 18, 0, 0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      int b0, b1, b2, d;
      b0 = $urandom_range(1, 6); b1 = $urandom_range(1, 6); b2 = $urandom_range(1, 6); d = $urandom_range(0, 3);
      setup(b0, b1, b2, d, 0);
      run(24'($urandom), (b0 + 2) + (b1 + 2) + (b2 + 2) + d, 0, 0);
    end
  endtask

  initial begin
    test_reset();
    test_happy();
    test_mux();
    test_delay();
    test_timeout();
    test_mid_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/arc4_ctrl.md
# arc4_ctrl

Sequencer for the ARC4 core: on one start request it runs `init`, then `ksa`, then `prga` in order over en/rdy handshakes. It time-multiplexes the single-port 256×8 S memory between the three engines and latches the key for the run. It sits between the top-level wrapper and the three engines, and flags a hung engine with a sticky error.

## Interface
- `TIMEOUT`, 1024: maximum cycles a phase may spend in START or WAIT before abort.
- `KEY_W`, 24: key width.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `en` in 1: start request; accepted only when `rdy`=1.
- `rdy` out 1: high when idle and able to accept `en`.
- `err` out 1: sticky timeout flag; cleared by the next accepted `en`.
- `phase` out 2: current S-memory owner (NONE/INIT/KSA/PRGA).
- `key` in KEY_W: key, sampled on the accepting edge.
- `key_q` out KEY_W: latched key, routed to ksa/prga.
- `init_en`/`ksa_en`/`prga_en` out 1 each: one-cycle start pulses.
- `init_rdy`/`ksa_rdy`/`prga_rdy` in 1 each: engine ready.
- `{init,ksa,prga}_addr` in 8: engine S address.
- `{init,ksa,prga}_wrdata` in 8: engine S write data.
- `{init,ksa,prga}_wren` in 1: engine S write enable.
- `s_addr` out 8: muxed S address.
- `s_wrdata` out 8: muxed S write data.
- `s_wren` out 1: muxed S write enable.

## Operation
- States: IDLE, START_INIT, WAIT_INIT, START_KSA, WAIT_KSA, START_PRGA, WAIT_PRGA.
- IDLE:
  - `rdy`=1, `phase`=NONE.
  - `en`=1 → latch `key_q`, clear `err` and the counter, go to START_INIT.
- START_x:
  - `x_en` = `x_rdy` (combinational), so it is asserted only while in START_x with `x_rdy` high.
  - `x_rdy`=1 → WAIT_x; otherwise stay.
- WAIT_x:
  - Engine contract: `x_rdy` is low in the cycle after its `en` cycle, and stays low for B≥1 cycles.
  - `x_rdy`=1 → START of the next phase; from WAIT_PRGA, go to IDLE.
- Phase owner:
  - INIT during START/WAIT_INIT, likewise for KSA and PRGA; NONE in IDLE.
  - `s_*` are driven from the owner's ports only. Non-owner `wren` is ignored.
  - With NONE: `s_addr`=0, `s_wrdata`=0, `s_wren`=0.
- `en` while `rdy`=0: ignored, no queueing.
- Timeout:
  - A 16-bit counter increments every cycle in a START or WAIT state and clears on every state change.
  - Counter reaches TIMEOUT-1 with the exit condition false → next state IDLE, `err`←1, `x_en` not asserted that cycle.
- Simultaneous events: the exit condition has priority over the timeout in the same cycle.

## Timing
- Reset values: state IDLE, `rdy`=1, `err`=0, `phase`=NONE, `key_q`=0, all `x_en`=0, `s_*`=0, counter=0.
- `rdy` drops in the cycle after the accepting edge.
- Per phase: 1 START cycle (engine ready) + B low cycles + 1 WAIT cycle with rdy high = B+2 cycles.
- `rdy` returns high exactly (B_init+2)+(B_ksa+2)+(B_prga+2) cycles after the accepting edge.
- `s_*` mux is combinational from the registered state. There is no added memory latency; `s_rddata` bypasses this block.
- Reset mid-run: everything returns asynchronously to reset values. Engines share `rst_n`; no partial-run state survives.
- `key_q` is stable from the cycle after the accept until the next accept.

## Structure
- `arc4_pkg`: state enum, phase enum (NONE=0, INIT=1, KSA=2, PRGA=3), `S_ADDR_W`=8, `S_DATA_W`=8, default `TIMEOUT`.
- Sub-module `arc4_smem_mux`: purely combinational three-way S-port mux keyed by `phase`.
- FSM, counter and key latch stay in `arc4_ctrl`.

## Test plan
- Reset: `rst_n`=0 → `rdy`=1, `err`=0, `phase`=0, `s_wren`=0, `key_q`=0.
- Happy path, B=3/5/4 engine models, `key`=24'h1E4600 → each `x_en` pulses once in order; `rdy` high again 18 cycles after the accept; `key_q`=24'h1E4600.
- Mux isolation, all engines driving `wren`=1 with distinct addresses (8'h11/22/33) → `s_addr` follows only the owner per phase; `s_wren`=0 in IDLE.
- Delayed readiness: `ksa_rdy`=0 for 4 cycles on entering START_KSA → `ksa_en` is not asserted until `ksa_rdy` rises; total latency grows by 4.
- Timeout, TIMEOUT=16, `prga_rdy` stuck low after its en → IDLE and `err`=1 within 16 cycles of entering WAIT_PRGA; next `en` clears `err`.
- Reset mid-run: `rst_n` pulsed low during WAIT_KSA → immediate `rdy`=1, `phase`=0; a fresh `en` restarts from init.
